// File: rtl/ahf_mrisc521_pkg.sv
// Shared types and constants for the switch input port: debounce FSM state and default settle time.
package ahf_mrisc521_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } deb_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int CNT_W            = 8;

endpackage

// File: rtl/ahf_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous level inputs.
// Latency: 2 cycles. Backpressure: none, samples every cycle.
module ahf_sync2 #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/ahf_sw_inport.sv
// Debounced board-switch input port with a single-entry read handshake and overrun flag.
// Latency: DEBOUNCE_CYCLES+3 edges from first sampling of a clean change to sw_valid.
// Backpressure: none; a new value overwrites an unread one and raises sw_ovr.
module ahf_sw_inport
    import ahf_mrisc521_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] sw_data,
    output logic             sw_valid,
    output logic             sw_ovr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;

    deb_state_t       state_q, state_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_data_q, sw_data_d;
    logic             sw_valid_q, sw_valid_d;
    logic             sw_ovr_q, sw_ovr_d;
    logic             commit;

    ahf_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk      (CLOCK_50),
        .rst_n    (Reset),
        .async_in (SW),
        .sync_out (sync_q)
    );

    always_comb begin
        state_d    = state_q;
        stable_d   = stable_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        sw_data_d  = sw_data_q;
        sw_valid_d = sw_valid_q;
        sw_ovr_d   = sw_ovr_q;
        commit     = 1'b0;

        unique case (state_q)
            ST_STABLE: begin
                if (sync_q != stable_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A bounce back to the accepted value is not a change at all.
                if (sync_q == stable_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit   = 1'b1;
                    stable_d = cand_q;
                    cnt_d    = '0;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        // A read landing on the commit edge consumes the old value, so no overrun.
        if (commit) begin
            sw_data_d  = cand_q;
            sw_valid_d = 1'b1;
            sw_ovr_d   = sw_valid_q & ~rd_ack;
        end else if (rd_ack && sw_valid_q) begin
            sw_valid_d = 1'b0;
            sw_ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_STABLE;
            stable_q   <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            sw_data_q  <= '0;
            sw_valid_q <= 1'b0;
            sw_ovr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stable_q   <= stable_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            sw_data_q  <= sw_data_d;
            sw_valid_q <= sw_valid_d;
            sw_ovr_q   <= sw_ovr_d;
        end
    end

    assign sw_data  = sw_data_q;
    assign sw_valid = sw_valid_q;
    assign sw_ovr   = sw_ovr_q;

endmodule

// File: tb/tb_ahf_sw_inport.sv
// Bench for ahf_sw_inport: directed debounce/handshake scenarios plus random switch traffic vs. a run-length model.
module tb_ahf_sw_inport;

    localparam int W = 5;
    localparam int D = 16;

    logic         CLOCK_50 = 1'b0;
    logic         Reset    = 1'b0;
    logic [W-1:0] SW       = '0;
    logic         rd_ack   = 1'b0;
    logic [W-1:0] sw_data;
    logic         sw_valid;
    logic         sw_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    ahf_sw_inport #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .SW       (SW),
        .rd_ack   (rd_ack),
        .sw_data  (sw_data),
        .sw_valid (sw_valid),
        .sw_ovr   (sw_ovr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: a value is accepted once the synchronized stream has shown
    // it on D+1 consecutive edges and it differs from the last accepted value.
    logic [W-1:0] m_pipe0 = '0, m_pipe1 = '0;
    logic [W-1:0] m_prev = '0, m_stable = '0, m_data = '0;
    logic         m_valid = 1'b0, m_ovr = 1'b0;
    int           m_run = 0;

    always @(posedge CLOCK_50 or negedge Reset) begin : model
        logic [W-1:0] seen;
        if (!Reset) begin
            m_pipe0 = '0; m_pipe1 = '0; m_prev = '0; m_stable = '0;
            m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_run = 0;
        end else begin
            seen = m_pipe1;
            if (seen == m_prev) begin
                if (m_run < 100000) m_run = m_run + 1;
            end else begin
                m_run = 1;
            end
            m_prev = seen;
            if (m_run == D + 1 && seen != m_stable) begin
                m_stable = seen;
                m_data   = seen;
                m_ovr    = m_valid && !rd_ack;
                m_valid  = 1'b1;
            end else if (rd_ack && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = SW;
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        Reset  = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        Reset = 1'b1;
    endtask

    // Runs edges until {sw_data,sw_valid} moves; optional one-cycle rd_ack landing on ack_edge.
    task automatic run_until_commit(input int max_edges, input int ack_edge, output int hit_edge);
        logic [W:0] start;
        start    = {sw_data, sw_valid};
        hit_edge = -1;
        for (int e = 1; e <= max_edges; e++) begin
            @(posedge CLOCK_50);
            #1;
            if (hit_edge < 0 && {sw_data, sw_valid} != start) hit_edge = e;
            if (e == ack_edge - 1) rd_ack = 1'b1;
            if (e == ack_edge) rd_ack = 1'b0;
            if (hit_edge >= 0) break;
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        SW = 5'b10101;
        @(negedge CLOCK_50);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({sw_data, sw_valid, sw_ovr} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%b valid=%b ovr=%b, want all 0", sw_data, sw_valid, sw_ovr);
        end
        SW = '0;
        repeat (3) @(negedge CLOCK_50);
        Reset = 1'b1;
    endtask

    task automatic test_clean_change();
        int hit;
        do_reset();
        SW = 5'b11010;
        run_until_commit(40, 0, hit);
        n_cmp++;
        if (hit !== D + 3) begin
            n_bad++;
            $display("FAIL clean_latency: commit edge=%0d, want %0d", hit, D + 3);
        end
        n_cmp++;
        if (sw_data !== 5'b11010 || sw_valid !== 1'b1 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_value: got data=%b valid=%b ovr=%b, want 11010/1/0", sw_data, sw_valid, sw_ovr);
        end
        for (int i = 0; i < 300; i++) begin
            @(posedge CLOCK_50);
            #1;
            n_cmp++;
            if (sw_data !== m_data || sw_valid !== m_valid || sw_ovr !== m_ovr) begin
                n_bad++;
                $display("FAIL clean_hold: cyc %0d got %b/%b/%b, want %b/%b/%b", i, sw_data, sw_valid, sw_ovr, m_data, m_valid, m_ovr);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        SW = 5'b10110;
        repeat (5) @(negedge CLOCK_50);
        SW = 5'b00000;
        repeat (40) @(negedge CLOCK_50);
        n_cmp++;
        if (sw_valid !== 1'b0 || sw_data !== 5'b0 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch: got data=%b valid=%b ovr=%b, want 00000/0/0", sw_data, sw_valid, sw_ovr);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            SW = s[0] ? 5'b01110 : 5'b01010;
            for (int c = 0; c < 8; c++) begin
                @(negedge CLOCK_50);
                n_cmp++;
                if (sw_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bounce_quiet: seg %0d got valid=%b, want 0", s, sw_valid);
                end
            end
        end
        repeat (40) @(negedge CLOCK_50);
        n_cmp++;
        if (sw_data !== 5'b01110 || sw_valid !== 1'b1 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_commit: got data=%b valid=%b ovr=%b, want 01110/1/0", sw_data, sw_valid, sw_ovr);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        SW = 5'b11110;
        repeat (25) @(negedge CLOCK_50);
        SW = 5'b01100;
        repeat (25) @(negedge CLOCK_50);
        n_cmp++;
        if (sw_data !== 5'b01100 || sw_valid !== 1'b1 || sw_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got data=%b valid=%b ovr=%b, want 01100/1/1", sw_data, sw_valid, sw_ovr);
        end
        rd_ack = 1'b1;
        @(negedge CLOCK_50);
        rd_ack = 1'b0;
        n_cmp++;
        if (sw_data !== 5'b01100 || sw_valid !== 1'b0 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_ack: got data=%b valid=%b ovr=%b, want 01100/0/0", sw_data, sw_valid, sw_ovr);
        end
        rd_ack = 1'b1;
        @(negedge CLOCK_50);
        rd_ack = 1'b0;
        n_cmp++;
        if (sw_data !== 5'b01100 || sw_valid !== 1'b0 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ack: got data=%b valid=%b ovr=%b, want 01100/0/0", sw_data, sw_valid, sw_ovr);
        end
    endtask

    task automatic test_ack_on_commit();
        int hit;
        do_reset();
        SW = 5'b00001;
        repeat (25) @(negedge CLOCK_50);
        SW = 5'b11000;
        run_until_commit(40, D + 3, hit);
        n_cmp++;
        if (hit !== D + 3) begin
            n_bad++;
            $display("FAIL ack_commit_edge: commit edge=%0d, want %0d", hit, D + 3);
        end
        n_cmp++;
        if (sw_data !== 5'b11000 || sw_valid !== 1'b1 || sw_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_on_commit: got data=%b valid=%b ovr=%b, want 11000/1/0", sw_data, sw_valid, sw_ovr);
        end
    endtask

    task automatic test_reset_mid_settle();
        int hit;
        do_reset();
        SW = 5'b00001;
        repeat (25) @(negedge CLOCK_50);
        SW = 5'b00110;
        repeat (10) @(posedge CLOCK_50);
        #1;
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({sw_data, sw_valid, sw_ovr} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got data=%b valid=%b ovr=%b, want all 0", sw_data, sw_valid, sw_ovr);
        end
        repeat (3) @(negedge CLOCK_50);
        n_cmp++;
        if ({sw_data, sw_valid, sw_ovr} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_hold: got data=%b valid=%b ovr=%b, want all 0", sw_data, sw_valid, sw_ovr);
        end
        Reset = 1'b1;
        run_until_commit(40, 0, hit);
        n_cmp++;
        if (hit !== D + 3 || sw_data !== 5'b00110 || sw_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_report: edge=%0d data=%b valid=%b, want edge %0d 00110/1", hit, sw_data, sw_valid, D + 3);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            SW   = W'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 2, D + 12) : $urandom_range(1, D + 6);
            for (int c = 0; c < hold; c++) begin
                @(posedge CLOCK_50);
                #1;
                n_cmp++;
                if (sw_data !== m_data || sw_valid !== m_valid || sw_ovr !== m_ovr) begin
                    n_bad++;
                    $display("FAIL random: seg %0d got %b/%b/%b, want %b/%b/%b", seg, sw_data, sw_valid, sw_ovr, m_data, m_valid, m_ovr);
                end
                rd_ack = ($urandom_range(0, 9) == 0);
            end
        end
        rd_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_overrun();
        test_ack_on_commit();
        test_reset_mid_settle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
